ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Single-port memory arbiter that shares one RAM port between the instruction-fetch path and the data-memory path of the pipelined datapath. It sits between the datapath-side fetch and load/store requests and the RAM. It grants one requester per transaction, holds the grant until the RAM completes or errors, and gives data accesses priority. A bounded starvation counter guarantees forward progress for instruction fetch.

## Interface
Parameters:
- STARVE_MAX, 3: number of consecutive data grants issued while fetch is pending before fetch is forced ahead of data.
- CNT_W, 2: width of the starvation counter; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- iREN  in  1  instruction read request; held until iwait low.
- iaddr  in  32  instruction address.
- iload  out  32  instruction data (pass-through of ramload).
- iwait  out  1  high while an iREN request is not yet completed.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins over dREN if both high.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dload  out  32  read data (pass-through of ramload).
- dwait  out  1  high while a dREN/dWEN request is not yet completed.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS (completes this cycle), 3 ERROR.
- err  out  1  one-cycle pulse when a granted transaction ends in ERROR.

## Operation
- FSM states: IDLE, IGNT, DGNT. Reset state is IDLE.
- IDLE decision:
  - If (dREN|dWEN) and not force_i, go to DGNT.
  - Else if iREN, go to IGNT.
  - Else stay in IDLE.
- force_i = iREN & (dREN|dWEN) & (starve_cnt == STARVE_MAX).
- starve_cnt update, applied only in IDLE when a grant is made:
  - DGNT grant with iREN high: increment by 1, saturating.
  - IGNT grant: clear to 0.
  - DGNT grant with iREN low: clear to 0.
- RAM outputs are Moore outputs, decoded from state:
  - IDLE: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - IGNT: ramREN=1, ramaddr=iaddr.
  - DGNT: ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore.
- Completion in IGNT/DGNT:
  - ramstate==ACCESS: the granted requester's wait goes low combinationally in the same cycle; next state is IDLE.
  - ramstate==ERROR: wait stays high and the requester retries; err pulses in this cycle; next state is IDLE.
  - FREE or BUSY: remain in the state.
- Abort: if the granted requester drops its enable before completion, next state is IDLE and no completion is signalled.
- Wait equations:
  - iwait = iREN & ~(state==IGNT & ramstate==ACCESS).
  - dwait = (dREN|dWEN) & ~(state==DGNT & ramstate==ACCESS).
- iload and dload always equal ramload. Data is valid only in the cycle the corresponding wait is low.
- Address and data inputs are sampled combinationally while granted. Requesters must hold them stable until wait is low.

## Timing
- Reset values: state=IDLE, starve_cnt=0, all ram* outputs 0, err=0. iwait and dwait follow their equations, so they are high if a request is asserted during reset.
- RST mid-transaction: at the next edge the state returns to IDLE, RAM enables drop, and no completion or err is issued.
- Minimum latency: request seen in IDLE at cycle n; RAM enable driven at cycle n+1; if ramstate==ACCESS at n+1, wait is low at n+1.
- Between transactions there is one mandatory IDLE cycle. Back-to-back grants are spaced at least 2 cycles apart.
- Simultaneous iREN and dREN in IDLE: data is granted, unless force_i is true.
- Worst-case fetch wait under continuous data traffic is bounded by STARVE_MAX+1 data transactions.
- err is high for exactly one cycle per ERROR completion. It is never asserted in IDLE.

## Test plan
- Reset with iREN=1: iwait=1, ramREN=0. Release RST; ramREN=1 and ramaddr=iaddr one cycle later. Drive ramstate=ACCESS with ramload=0x8C220004: iwait=0 and iload=0x8C220004 in that cycle; state is IDLE the next cycle.
- Issue iREN and dWEN together with daddr=0x100 and dstore=0xDEADBEEF: DGNT with ramWEN=1 and ramstore=0xDEADBEEF. Complete after 3 BUSY cycles: dwait low on the ACCESS cycle; iREN granted 2 cycles later.
- Hold iREN high with dREN continuously high: exactly 3 data grants occur, then the 4th grant is IGNT. starve_cnt returns to 0 after that grant.
- Granted DGNT read, then ramstate=ERROR: err=1 for one cycle and dwait remains 1. The arbiter re-grants the data read after the IDLE cycle and completes on ACCESS.
- Assert RST during IGNT with ramstate=BUSY: the next cycle is IDLE with ramREN=0. No iwait-low pulse and no err occur.
- Assert dREN and dWEN together: ramWEN=1 and ramREN=0. Drop dWEN mid-grant: the arbiter returns to IDLE with no completion, then re-grants as a read.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: fetch, data and RAM port signals shared by the arbiter and its surroundings
interface ram_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between fetch and data with data priority and bounded fetch starvation
module ram_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 2
) (
  input logic         CLK,
  input logic         RST,
  ram_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IGNT   = 2'd1;
  localparam logic [1:0] DGNT   = 2'd2;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic             dreq, force_i, act_i, act_d, done, fail;
  always_comb begin
    dreq    = bus.dREN | bus.dWEN;
    force_i = bus.iREN & dreq & (cnt_q == CNT_W'(STARVE_MAX));
    act_i   = (state_q == IGNT) & bus.iREN;
    act_d   = (state_q == DGNT) & dreq & (bus.dWEN == wr_q);
    done    = ~RST & (bus.ramstate == ACCESS);
    fail    = ~RST & (bus.ramstate == ERROR);
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    if (state_q == IDLE) begin
      if (dreq & ~force_i) begin
        state_d = DGNT;
        wr_d    = bus.dWEN;
        cnt_d   = bus.iREN ? (&cnt_q ? cnt_q : cnt_q + 1'b1) : '0;
      end else if (bus.iREN) begin
        state_d = IGNT;
        cnt_d   = '0;
      end
    end else if (~(act_i | act_d) | done | fail) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
    end
  end
  assign bus.ramREN   = (state_q == IGNT) | ((state_q == DGNT) & bus.dREN & ~bus.dWEN);
  assign bus.ramWEN   = (state_q == DGNT) & bus.dWEN;
  assign bus.ramaddr  = (state_q == IGNT) ? bus.iaddr : (state_q == DGNT) ? bus.daddr : '0;
  assign bus.ramstore = (state_q == DGNT) ? bus.dstore : '0;
  assign bus.iwait    = bus.iREN & ~(act_i & done);
  assign bus.dwait    = dreq & ~(act_d & done);
  assign bus.err      = (act_i | act_d) & fail;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against a transaction-level model
module tb_ram_arbiter;
  localparam int SMAX = 3;
  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  int   owner  = 0;
  int   streak = 0;
  bit   own_wr = 1'b0;
  int   grants[8];
  int   ng;
  ram_arbiter_if bus ();
  ram_arbiter dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    bit dreq, ai, ad, dn, fl;
    dreq = bus.dREN | bus.dWEN;
    ai   = owner == 1 && bus.iREN;
    ad   = owner == 2 && dreq && bus.dWEN == own_wr;
    dn   = !rst && bus.ramstate == 2'd2;
    fl   = !rst && bus.ramstate == 2'd3;
    chk("m_iwait", bus.iwait, bus.iREN && !(ai && dn));
    chk("m_dwait", bus.dwait, dreq && !(ad && dn));
    chk("m_err", bus.err, (ai || ad) && fl);
    chk("m_ramREN", bus.ramREN, owner == 1 || (owner == 2 && bus.dREN && !bus.dWEN));
    chk("m_ramWEN", bus.ramWEN, owner == 2 && bus.dWEN);
    chk("m_ramaddr", bus.ramaddr, owner == 1 ? bus.iaddr : owner == 2 ? bus.daddr : 32'h0);
    chk("m_ramstore", bus.ramstore, owner == 2 ? bus.dstore : 32'h0);
    chk("m_iload", bus.iload, bus.ramload);
    chk("m_dload", bus.dload, bus.ramload);
  endtask
  task automatic model_update();
    bit dreq;
    dreq = bus.dREN | bus.dWEN;
    if (rst) begin
      owner  = 0;
      streak = 0;
    end else if (owner == 0) begin
      if (dreq && !(bus.iREN && streak == SMAX)) begin
        owner  = 2;
        own_wr = bus.dWEN;
        streak = bus.iREN ? (streak < 3 ? streak + 1 : 3) : 0;
      end else if (bus.iREN) begin
        owner  = 1;
        streak = 0;
      end
    end else if (owner == 1) begin
      if (!bus.iREN || bus.ramstate >= 2'd2) owner = 0;
    end else begin
      if (!dreq || bus.dWEN != own_wr || bus.ramstate >= 2'd2) owner = 0;
    end
  endtask
  task automatic look();
    #1;
    check_all();
  endtask
  task automatic cyc();
    model_update();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    bus.iREN = 1'b1;
    bus.iaddr = 32'h40;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    bus.daddr = 32'h0;
    bus.dstore = 32'h0;
    bus.ramload = 32'h0;
    bus.ramstate = 2'd0;
    @(posedge clk);
    #1;
    look();
    chk("rst_iwait", bus.iwait, 1);
    chk("rst_ramREN", bus.ramREN, 0);
    chk("rst_err", bus.err, 0);
    cyc();
    rst = 1'b0;
    look();
    chk("idle_ramREN", bus.ramREN, 0);
    cyc();
    bus.ramstate = 2'd2;
    bus.ramload = 32'h8C220004;
    look();
    chk("ig_ramREN", bus.ramREN, 1);
    chk("ig_ramaddr", bus.ramaddr, 32'h40);
    chk("ig_iwait", bus.iwait, 0);
    chk("ig_iload", bus.iload, 32'h8C220004);
    cyc();
    bus.iREN = 1'b0;
    bus.ramstate = 2'd0;
    look();
    chk("ig_idle_after", bus.ramREN, 0);
    cyc();
    bus.iREN = 1'b1;
    bus.dWEN = 1'b1;
    bus.daddr = 32'h100;
    bus.dstore = 32'hDEADBEEF;
    look();
    cyc();
    bus.ramstate = 2'd1;
    for (int k = 0; k < 3; k++) begin
      look();
      chk("dw_ramWEN", bus.ramWEN, 1);
      chk("dw_ramstore", bus.ramstore, 32'hDEADBEEF);
      chk("dw_ramaddr", bus.ramaddr, 32'h100);
      chk("dw_dwait_busy", bus.dwait, 1);
      cyc();
    end
    bus.ramstate = 2'd2;
    look();
    chk("dw_dwait_done", bus.dwait, 0);
    cyc();
    bus.dWEN = 1'b0;
    bus.ramstate = 2'd0;
    look();
    chk("dw_gap_idle", bus.ramREN | bus.ramWEN, 0);
    cyc();
    bus.ramstate = 2'd2;
    look();
    chk("dw_then_ig", bus.ramREN, 1);
    chk("dw_then_ig_addr", bus.ramaddr, 32'h40);
    cyc();
    bus.dREN = 1'b1;
    bus.daddr = 32'h300;
    ng = 0;
    for (int k = 0; k < 40 && ng < 8; k++) begin
      look();
      if (bus.ramREN | bus.ramWEN) begin
        grants[ng] = (bus.ramaddr == 32'h40) ? 1 : 2;
        ng++;
      end
      cyc();
    end
    chk("starve_ngrants", ng, 8);
    for (int k = 0; k < 8; k++) chk($sformatf("starve_grant%0d", k), grants[k], (k % 4 == 3) ? 1 : 2);
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    bus.ramstate = 2'd0;
    look();
    cyc();
    look();
    cyc();
    bus.dREN = 1'b1;
    bus.daddr = 32'h200;
    look();
    cyc();
    bus.ramstate = 2'd3;
    look();
    chk("er_err", bus.err, 1);
    chk("er_dwait", bus.dwait, 1);
    chk("er_ramREN", bus.ramREN, 1);
    cyc();
    bus.ramstate = 2'd0;
    look();
    chk("er_err_gone", bus.err, 0);
    chk("er_idle", bus.ramREN, 0);
    cyc();
    bus.ramstate = 2'd2;
    bus.ramload = 32'h12345678;
    look();
    chk("er_retry_dwait", bus.dwait, 0);
    chk("er_retry_dload", bus.dload, 32'h12345678);
    cyc();
    bus.dREN = 1'b0;
    bus.iREN = 1'b1;
    bus.ramstate = 2'd0;
    look();
    cyc();
    bus.ramstate = 2'd1;
    rst = 1'b1;
    look();
    chk("rs_ramREN_before", bus.ramREN, 1);
    chk("rs_iwait", bus.iwait, 1);
    chk("rs_err", bus.err, 0);
    cyc();
    rst = 1'b0;
    look();
    chk("rs_ramREN_after", bus.ramREN, 0);
    chk("rs_iwait_after", bus.iwait, 1);
    cyc();
    bus.iREN = 1'b0;
    look();
    cyc();
    bus.dREN = 1'b1;
    bus.dWEN = 1'b1;
    bus.ramstate = 2'd0;
    look();
    cyc();
    bus.ramstate = 2'd1;
    look();
    chk("ab_ramWEN", bus.ramWEN, 1);
    chk("ab_ramREN", bus.ramREN, 0);
    cyc();
    bus.dWEN = 1'b0;
    look();
    chk("ab_dwait", bus.dwait, 1);
    cyc();
    look();
    chk("ab_idle", bus.ramREN | bus.ramWEN, 0);
    cyc();
    bus.ramstate = 2'd2;
    look();
    chk("ab_read_REN", bus.ramREN, 1);
    chk("ab_read_WEN", bus.ramWEN, 0);
    chk("ab_read_dwait", bus.dwait, 0);
    cyc();
    bus.dREN = 1'b0;
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom % 40) == 0;
      if ($urandom % 4 == 0) bus.iREN = ~bus.iREN;
      if ($urandom % 4 == 0) bus.dREN = ~bus.dREN;
      if ($urandom % 6 == 0) bus.dWEN = ~bus.dWEN;
      bus.ramstate = 2'($urandom % 4);
      bus.iaddr = $urandom;
      bus.daddr = $urandom;
      bus.dstore = $urandom;
      bus.ramload = $urandom;
      look();
      cyc();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
